pc_gen: RTL and testbench

Parametrised fetch program-counter generator for the RV32I pipeline. It adds several things to a plain stallable PC register: a fetch handshake, prioritised redirect sources (pipeline flush and branch), a pending-redirect buffer that holds a branch target across stalls, misaligned-target detection with a halt state, and a fetch counter. It sits at the head of IF and drives the instruction memory address and the IF/ID pc fields.

---
 rtl/pc_gen.sv | 167 ++++++++++++++++
 tb/tb_pc_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with prioritised flush/branch redirects, a pending-branch buffer, misalign halt and fetch counter.
// Latency: a redirect target appears on pc one cycle after its sampling edge; the first valid fetch comes one cycle after reset.
// Backpressure: stall or !fetch_ready holds pc; a flush overrides stall; a branch seen under stall is buffered until stall drops.
module pc_gen #(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int unsigned       INC          = 4,
    parameter int unsigned       CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             flush_valid,
    input  logic [XLEN-1:0]  flush_pc,
    input  logic             branch_valid,
    input  logic [XLEN-1:0]  branch_pc,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus,
    output logic             pc_valid,
    output logic             misalign,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    // Sequential step and the mask of address bits that must be zero in any target.
    localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,  // just out of reset, no fetch request yet
        RUN  = 2'd1,  // normal sequential fetch
        PEND = 2'd2,  // a branch target is parked until stall drops
        HALT = 2'd3   // a misaligned target was rejected; wait for a good flush
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic              pc_valid_q, pc_valid_d;
    logic              misalign_q, misalign_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

    logic              acc;
    logic              flush_ok;
    logic              branch_ok;
    logic [XLEN-1:0]   pc_plus_w;

    assign pc_plus_w = pc_q + INC_X;
    assign acc       = pc_valid_q & fetch_ready & ~stall;
    assign flush_ok  = (flush_pc & ALIGN_MASK) == '0;
    assign branch_ok = (branch_pc & ALIGN_MASK) == '0;

    // Next-state selection: flush beats branch beats pending release beats sequential advance.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        pend_valid_d  = pend_valid_q;
        misalign_d    = 1'b0;
        fetch_count_d = acc ? fetch_count_q + CNT_W'(1) : fetch_count_q;

        unique case (state_q)
            BOOT: begin
                if (flush_valid) begin
                    if (flush_ok) begin
                        pc_d    = flush_pc;
                        state_d = RUN;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end
                end else begin
                    // pc keeps RESET_VECTOR and becomes a valid request
                    state_d = RUN;
                end
            end

            RUN, PEND: begin
                if (flush_valid) begin
                    // a flush ignores stall/fetch_ready and discards any parked branch
                    pend_valid_d = 1'b0;
                    if (flush_ok) begin
                        pc_d    = flush_pc;
                        state_d = RUN;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end
                end else if (branch_valid) begin
                    if (!branch_ok) begin
                        misalign_d   = 1'b1;
                        pend_valid_d = 1'b0;
                        state_d      = HALT;
                    end else if (!stall) begin
                        // a fresh branch at release time supersedes the parked one
                        pc_d         = branch_pc;
                        pend_valid_d = 1'b0;
                        state_d      = RUN;
                    end else begin
                        // newest branch wins the buffer
                        pend_pc_d    = branch_pc;
                        pend_valid_d = 1'b1;
                        state_d      = PEND;
                    end
                end else if (state_q == PEND) begin
                    // release ignores fetch_ready: the stale pc's fetch is abandoned
                    if (!stall && pend_valid_q) begin
                        pc_d         = pend_pc_q;
                        pend_valid_d = 1'b0;
                        state_d      = RUN;
                    end
                end else if (acc) begin
                    pc_d = pc_plus_w;
                end
            end

            HALT: begin
                // only an aligned flush leaves HALT; branches are ignored
                if (flush_valid && flush_ok) begin
                    pc_d    = flush_pc;
                    state_d = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase

        pc_valid_d = (state_d == RUN) || (state_d == PEND);
        halted_d   = (state_d == HALT);
    end

    // State and registered outputs; reset drops any parked target and restarts in BOOT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            pend_pc_q     <= '0;
            pend_valid_q  <= 1'b0;
            pc_valid_q    <= 1'b0;
            misalign_q    <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            pend_valid_q  <= pend_valid_d;
            pc_valid_q    <= pc_valid_d;
            misalign_q    <= misalign_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus     = pc_plus_w;
    assign pc_valid    = pc_valid_q;
    assign misalign    = misalign_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and random stimulus for pc_gen against a rule-level reference model.
// Latency: checks one time unit after each rising edge.
// Backpressure: stall/fetch_ready/redirects are driven directly; no handshake on the bench side.
module tb_pc_gen;

    localparam int unsigned      XLEN  = 32;
    localparam logic [31:0]      RV    = 32'h0000_0100;
    localparam int unsigned      INC   = 4;
    localparam int unsigned      CNT_W = 8;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b1;
    logic        stall        = 1'b0;
    logic        fetch_ready  = 1'b0;
    logic        flush_valid  = 1'b0;
    logic [31:0] flush_pc     = '0;
    logic        branch_valid = 1'b0;
    logic [31:0] branch_pc    = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        pc_valid;
    logic        misalign;
    logic        halted;
    logic [7:0]  fetch_count;

    int total = 0;
    int bad   = 0;

    // reference model state, in terms of the behavioural rules
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_halt;
    bit          m_mis;
    int          m_cnt;
    logic [31:0] m_pend[$];

    pc_gen #(
        .XLEN        (XLEN),
        .RESET_VECTOR(RV),
        .INC         (INC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .flush_valid (flush_valid),
        .flush_pc    (flush_pc),
        .branch_valid(branch_valid),
        .branch_pc   (branch_pc),
        .pc          (pc),
        .pc_plus     (pc_plus),
        .pc_valid    (pc_valid),
        .misalign    (misalign),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = RV;
        m_boot = 1'b1;
        m_halt = 1'b0;
        m_mis  = 1'b0;
        m_cnt  = 0;
        m_pend.delete();
    endtask

    function automatic bit aligned(input logic [31:0] t);
        return (t % INC) == 0;
    endfunction

    // One clock edge of the rules: inputs as sampled at that edge.
    task automatic model_edge(input bit s, input bit fr, input bit fv, input logic [31:0] fp,
                              input bit bv, input logic [31:0] bp);
        bit valid_now;
        bit accepted;
        valid_now = !m_boot && !m_halt;
        accepted  = valid_now && fr && !s;
        if (accepted) m_cnt = (m_cnt + 1) % 256;
        m_mis = 1'b0;
        if (m_halt) begin
            if (fv && aligned(fp)) begin
                m_halt = 1'b0;
                m_pc   = fp;
            end
        end else if (fv) begin
            m_boot = 1'b0;
            m_pend.delete();
            if (aligned(fp)) m_pc = fp;
            else begin
                m_mis  = 1'b1;
                m_halt = 1'b1;
            end
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (bv) begin
            if (!aligned(bp)) begin
                m_mis  = 1'b1;
                m_halt = 1'b1;
                m_pend.delete();
            end else if (!s) begin
                m_pc = bp;
                m_pend.delete();
            end else begin
                m_pend.delete();
                m_pend.push_back(bp);
            end
        end else if (m_pend.size() != 0) begin
            if (!s) m_pc = m_pend.pop_front();
        end else if (accepted) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".pc"},       pc,                      m_pc);
        chk({where, ".pc_plus"},  pc_plus,                 m_pc + 32'd4);
        chk({where, ".pc_valid"}, {31'd0, pc_valid},       {31'd0, (!m_boot && !m_halt)});
        chk({where, ".halted"},   {31'd0, halted},         {31'd0, m_halt});
        chk({where, ".misalign"}, {31'd0, misalign},       {31'd0, m_mis});
        chk({where, ".count"},    {24'd0, fetch_count},    32'(m_cnt));
    endtask

    task automatic step(input string where, input bit s, input bit fr, input bit fv,
                        input logic [31:0] fp, input bit bv, input logic [31:0] bp);
        stall        = s;
        fetch_ready  = fr;
        flush_valid  = fv;
        flush_pc     = fp;
        branch_valid = bv;
        branch_pc    = bp;
        @(posedge clk);
        #1;
        model_edge(s, fr, fv, fp, bv, bp);
        check_all(where);
    endtask

    // Pull reset low between edges, check the immediate effect, release on a falling edge.
    task automatic async_reset(input string where);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(where);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        int r;
        r = $urandom_range(19);
        t = $urandom;
        if (r == 0)      t = 32'hFFFF_FFFC;
        else if (r == 1) t = t | 32'h2;
        else if (r == 2) t = t | 32'h1;
        else             t = t & ~32'h3;
        return t;
    endfunction

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #11;
        check_all("reset");
        chk("reset.pc_const", pc, 32'h100);
        chk("reset.valid_const", {31'd0, pc_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // boot then sequential fetch
        step("boot", 0, 1, 0, 0, 0, 0);
        chk("boot.pc_const", pc, 32'h100);
        chk("boot.valid_const", {31'd0, pc_valid}, 32'd1);
        step("seq1", 0, 1, 0, 0, 0, 0);
        step("seq2", 0, 1, 0, 0, 0, 0);
        chk("seq2.pc_const", pc, 32'h108);

        // stall and not-ready hold pc and count
        step("stall1", 1, 1, 0, 0, 0, 0);
        step("stall2", 1, 1, 0, 0, 0, 0);
        chk("stall.pc_const", pc, 32'h108);
        chk("stall.cnt_const", {24'd0, fetch_count}, 32'd2);
        step("notrdy", 0, 0, 0, 0, 0, 0);
        chk("notrdy.pc_const", pc, 32'h108);
        step("resume", 0, 1, 0, 0, 0, 0);
        chk("resume.pc_const", pc, 32'h10C);
        chk("resume.cnt_const", {24'd0, fetch_count}, 32'd3);

        // branch held across stall, applied on release
        step("fl200", 0, 0, 1, 32'h200, 0, 0);
        step("pendset", 1, 1, 0, 0, 1, 32'h400);
        for (int i = 0; i < 3; i++) step("pendhold", 1, 1, 0, 0, 0, 0);
        chk("pendhold.pc_const", pc, 32'h200);
        step("pendrel", 0, 1, 0, 0, 0, 0);
        chk("pendrel.pc_const", pc, 32'h400);
        step("pendnext", 0, 1, 0, 0, 0, 0);
        chk("pendnext.pc_const", pc, 32'h404);

        // flush beats branch under stall; branch is lost
        step("prio", 1, 1, 1, 32'h800, 1, 32'h400);
        chk("prio.pc_const", pc, 32'h800);
        step("prio_hold", 0, 0, 0, 0, 0, 0);
        chk("prio_hold.pc_const", pc, 32'h800);

        // misaligned branch halts; branches ignored; aligned flush recovers
        step("mis", 0, 1, 0, 0, 1, 32'h402);
        chk("mis.pulse_const", {31'd0, misalign}, 32'd1);
        chk("mis.halt_const", {31'd0, halted}, 32'd1);
        step("halt_br", 0, 1, 0, 0, 1, 32'h500);
        chk("halt_br.pulse_const", {31'd0, misalign}, 32'd0);
        step("halt_fl", 0, 1, 1, 32'h600, 0, 0);
        chk("halt_fl.pc_const", pc, 32'h600);
        chk("halt_fl.valid_const", {31'd0, pc_valid}, 32'd1);

        // address wrap
        step("wrapset", 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("wrapset.plus_const", pc_plus, 32'h0);
        step("wrap", 0, 1, 0, 0, 0, 0);
        chk("wrap.pc_const", pc, 32'h0);

        // async reset while a branch is parked
        step("fl300", 0, 0, 1, 32'h300, 0, 0);
        step("pend2", 1, 0, 0, 0, 1, 32'h700);
        async_reset("arst");
        chk("arst.pc_const", pc, 32'h100);
        step("arst_boot", 0, 0, 0, 0, 0, 0);
        step("arst_nopend", 0, 0, 0, 0, 0, 0);
        chk("arst_nopend.pc_const", pc, 32'h100);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bit s, fr, fv, bv;
            s  = ($urandom_range(9) < 3);
            fr = ($urandom_range(9) < 7);
            fv = ($urandom_range(19) == 0);
            bv = ($urandom_range(19) < 3);
            step("rand", s, fr, fv, rand_target(), bv, rand_target());
            if (i % 500 == 499) async_reset("rand_arst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
